// File: rtl/encrypt_pkg.sv
// Shared widths, types and helpers for the encrypt output path.
package encrypt_pkg;

   localparam int BYTE_W = 8;
   localparam int WORD_W = 32;
   localparam int LANES  = 4;
   localparam int LANE_W = $clog2(LANES);
   // Accumulator covers every lane except the last, which completes the word directly.
   localparam int ACC_W  = (LANES - 1) * BYTE_W;
   // One FIFO entry carries the keep flags above the data word.
   localparam int ENTRY_W = WORD_W + LANES;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [LANES-1:0]  keep_t;

   // Keep mask with the lowest 'lanes' bits set.
   function automatic keep_t keep_mask(input logic [LANE_W:0] lanes);
      logic [LANES:0] mask;
      mask = ({{LANES{1'b0}}, 1'b1} << lanes) - {{LANES{1'b0}}, 1'b1};
      return mask[LANES-1:0];
   endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// Show-ahead FIFO of packed words with keep flags. The head entry is always
// presented on head_data; an empty FIFO presents zero.
import encrypt_pkg::*;

module sync_word_fifo #(
   parameter  int DEPTH = 4,
   localparam int LW    = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic [ENTRY_W-1:0] push_data,
   input  logic               pop,
   output logic [ENTRY_W-1:0] head_data,
   output logic               full,
   output logic               empty,
   output logic [LW-1:0]      level
);

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [LW-1:0]      wr_ptr_reg;
   logic [LW-1:0]      rd_ptr_reg;
   logic               do_pop;
   logic               do_push;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign level  = wr_ptr_reg - rd_ptr_reg;
   assign empty  = (level == '0);
   assign full   = (level == LW'(DEPTH));
   assign do_pop = pop && !empty;
   // A pop on the same edge frees the slot a full-FIFO push needs.
   assign do_push = push && (!full || do_pop);

   assign head_data = empty ? '0 : mem[rd_ptr_reg[LW-2:0]];

   // Storage write; contents need no reset because empty masks the head.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg[LW-2:0]] <= push_data;
      end
   end

   // Pointer advance on accepted push and pop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

endmodule

// File: rtl/encrypt_out_packer.sv
// Packs the encrypt stage's byte stream little-endian into 32-bit words with
// keep flags and queues them for the output bus. The byte source cannot be
// stalled, so a word arriving at a full FIFO is dropped and flagged.
import encrypt_pkg::*;

module encrypt_out_packer #(
   parameter  int DEPTH = 4,
   localparam int LW    = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] byte_in,
   input  logic              byte_valid,
   input  logic              flush,
   output word_t             word_out,
   output keep_t             word_keep,
   output logic              word_valid,
   input  logic              word_ready,
   output logic [LW-1:0]     level,
   output logic              overflow
);

   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

   logic [LANE_W-1:0]  lane_reg;
   logic [LANE_W-1:0]  lane_next;
   logic [ACC_W-1:0]   acc_reg;
   logic [ACC_W-1:0]   acc_next;
   logic [ACC_W-1:0]   acc_ins;
   logic               overflow_reg;

   logic               push;
   word_t              push_word;
   keep_t              push_keep;
   logic               pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [ENTRY_W-1:0] head_data;

   // Accumulator with the incoming byte dropped into the current lane.
   genvar gi;
   generate
      for (gi = 0; gi < LANES - 1; gi++) begin : g_lane
         assign acc_ins[gi*BYTE_W +: BYTE_W] =
            (lane_reg == LANE_W'(gi)) ? byte_in : acc_reg[gi*BYTE_W +: BYTE_W];
      end
   endgenerate

   // Byte packing first, then flush of whatever partial word remains.
   always_comb begin
      push      = 1'b0;
      push_word = '0;
      push_keep = '0;
      lane_next = lane_reg;
      acc_next  = acc_reg;
      if (byte_valid) begin
         if (lane_reg == LAST_LANE) begin
            push      = 1'b1;
            push_word = {byte_in, acc_reg};
            push_keep = '1;
            lane_next = '0;
            acc_next  = '0;
         end else begin
            acc_next  = acc_ins;
            lane_next = lane_reg + 1'b1;
         end
      end
      // A byte that just completed a word leaves lane_next at 0, so the flush is a no-op.
      if (flush && (lane_next != '0)) begin
         push      = 1'b1;
         push_word = {{BYTE_W{1'b0}}, acc_next};
         push_keep = keep_mask({1'b0, lane_next});
         lane_next = '0;
         acc_next  = '0;
      end
   end

   // Packer state and sticky overflow flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lane_reg     <= '0;
         acc_reg      <= '0;
         overflow_reg <= 1'b0;
      end else begin
         lane_reg <= lane_next;
         acc_reg  <= acc_next;
         if (push && fifo_full && !pop) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   assign pop = word_valid && word_ready;

   sync_word_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({push_keep, push_word}),
      .pop       (pop),
      .head_data (head_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (level)
   );

   assign word_out   = head_data[WORD_W-1:0];
   assign word_keep  = head_data[ENTRY_W-1:WORD_W];
   assign word_valid = !fifo_empty;
   assign overflow   = overflow_reg;

endmodule

// File: tb/tb_encrypt_out_packer.sv
// Directed bench for encrypt_out_packer with hand-computed expected words.
module tb_encrypt_out_packer;

   logic        clk;
   logic        rst;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        flush;
   logic [31:0] word_out;
   logic [3:0]  word_keep;
   logic        word_valid;
   logic        word_ready;
   logic [2:0]  level;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   encrypt_out_packer #(.DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .flush      (flush),
      .word_out   (word_out),
      .word_keep  (word_keep),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .level      (level),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   // Advance one clock edge; outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      byte_in    = b;
      byte_valid = 1'b1;
      tick();
      byte_valid = 1'b0;
   endtask

   task automatic check_head(input string tag, input logic [31:0] w, input logic [3:0] k);
      check({tag, "_word"}, word_out, w);
      check({tag, "_keep"}, {28'b0, word_keep}, {28'b0, k});
      check({tag, "_valid"}, {31'b0, word_valid}, 32'd1);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_word"}, word_out, 32'h0);
      check({tag, "_keep"}, {28'b0, word_keep}, 32'h0);
      check({tag, "_valid"}, {31'b0, word_valid}, 32'd0);
      check({tag, "_level"}, {29'b0, level}, 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   initial begin
      rst        = 1'b0;
      byte_in    = 8'h00;
      byte_valid = 1'b0;
      flush      = 1'b0;
      word_ready = 1'b0;
      tick();
      tick();
      check_idle("reset");
      check("reset_ovf", {31'b0, overflow}, 32'd0);
      rst = 1'b1;
      tick();

      // Full word with the consumer ready.
      word_ready = 1'b1;
      send(8'h11); send(8'h22); send(8'h33);
      check("t1_not_yet", {31'b0, word_valid}, 32'd0);
      send(8'h44);
      check_head("t1", 32'h44332211, 4'hF);
      check("t1_level1", {29'b0, level}, 32'd1);
      tick();
      check_idle("t1_drained");

      // Partial word via flush, then a flush with nothing pending.
      send(8'hAA); send(8'hBB);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check_head("t2", 32'h0000BBAA, 4'b0011);
      tick();
      check_idle("t2_drained");
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("t2_noflush", {31'b0, word_valid}, 32'd0);
      tick();
      check("t2_noflush2", {29'b0, level}, 32'd0);

      // Completing byte and flush on the same cycle: one full word only.
      send(8'h01); send(8'h02); send(8'h03);
      flush = 1'b1;
      send(8'h04);
      flush = 1'b0;
      check_head("t3", 32'h04030201, 4'hF);
      check("t3_level", {29'b0, level}, 32'd1);
      tick();
      check_idle("t3_no_extra");

      // Overflow: five words into a four-deep FIFO with no consumer.
      word_ready = 1'b0;
      for (int i = 0; i < 16; i++) send(8'(i));
      check("t4_level_full", {29'b0, level}, 32'd4);
      check("t4_ovf_before", {31'b0, overflow}, 32'd0);
      for (int i = 16; i < 20; i++) send(8'(i));
      check("t4_level_sat", {29'b0, level}, 32'd4);
      check("t4_ovf", {31'b0, overflow}, 32'd1);
      word_ready = 1'b1;
      check_head("t4_d0", 32'h03020100, 4'hF); tick();
      check_head("t4_d1", 32'h07060504, 4'hF); tick();
      check_head("t4_d2", 32'h0B0A0908, 4'hF); tick();
      check_head("t4_d3", 32'h0F0E0D0C, 4'hF); tick();
      check_idle("t4_lost");
      check("t4_ovf_sticky", {31'b0, overflow}, 32'd1);

      // Push into a full FIFO on the same edge as a pop.
      do_reset();
      check("t5_ovf_clr", {31'b0, overflow}, 32'd0);
      word_ready = 1'b0;
      for (int i = 0; i < 19; i++) send(8'(8'h20 + i));
      check("t5_level_full", {29'b0, level}, 32'd4);
      word_ready = 1'b1;
      send(8'h33);
      word_ready = 1'b0;
      check("t5_level", {29'b0, level}, 32'd4);
      check("t5_ovf", {31'b0, overflow}, 32'd0);
      word_ready = 1'b1;
      check_head("t5_d0", 32'h27262524, 4'hF); tick();
      check_head("t5_d1", 32'h2B2A2928, 4'hF); tick();
      check_head("t5_d2", 32'h2F2E2D2C, 4'hF); tick();
      check_head("t5_d3", 32'h33323130, 4'hF); tick();
      check_idle("t5_empty");

      // Asynchronous reset mid-stream.
      word_ready = 1'b0;
      for (int i = 0; i < 10; i++) send(8'(8'h50 + i));
      check("t6_level", {29'b0, level}, 32'd2);
      rst = 1'b0;
      #1;
      check_idle("t6_async");
      check("t6_ovf", {31'b0, overflow}, 32'd0);
      tick();
      rst = 1'b1;
      tick();
      word_ready = 1'b1;
      send(8'h60); send(8'h61); send(8'h62);
      check("t6_clean_pending", {31'b0, word_valid}, 32'd0);
      send(8'h63);
      check_head("t6_clean", 32'h63626160, 4'hF);
      tick();
      check_idle("t6_done");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/encrypt_out_packer.md
Name: encrypt_out_packer

Overview:
- Downstream neighbour of the XOR/key-rotation encrypt stage.
- Consumes its registered byte stream (encrypted_data / encrypted_valid) and packs bytes little-endian into 32-bit words with per-byte keep flags.
- Buffers packed words in a small FIFO and presents them on a valid/ready interface to the output bus.
- The encrypt stage cannot be stalled, so the FIFO absorbs bursts; any loss is flagged as overflow.

Parameters:
- DEPTH, 4, number of 32-bit word entries in the FIFO. Must be a power of 2 and at least 2.
- LW, $clog2(DEPTH)+1, width of the fill-level output. Derived; not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- byte_in  in  8  encrypted byte from the upstream stage.
- byte_valid  in  1  byte_in is valid this cycle. There is no backpressure on this input.
- flush  in  1  single-cycle pulse: emit any partial word.
- word_out  out  32  packed word. Lane 0 is bits [7:0] and holds the earliest byte.
- word_keep  out  4  keep bit per lane. Bit i set means lane i is valid.
- word_valid  out  1  FIFO head is valid.
- word_ready  in  1  consumer accepts the head word.
- level  out  LW  number of words currently held in the FIFO.
- overflow  out  1  sticky: a word was dropped.

Behaviour:
- Reset (rst=0, asynchronous): lane counter=0, accumulator=0, FIFO empty, level=0, word_valid=0, word_out=0, word_keep=0, overflow=0. Reset mid-operation discards the partial word and all FIFO contents with no flag.
- Packing: a 2-bit lane counter plus a 24-bit accumulator for lanes 0..2.
- byte_valid=1 with lane<3: store byte_in into lane, then lane+1.
- byte_valid=1 with lane=3: form word {byte_in, acc}, keep=4'b1111, push it in the same edge, lane wraps to 0, accumulator cleared.
- flush=1 with lane>0 (after counting any byte arriving this cycle): push the partial word. Unused lanes are 0; keep = (1<<filled)-1 (e.g. 2 bytes gives 4'b0011). Lane goes to 0.
- flush and byte_valid in the same cycle: the byte is packed first, then the flush applies. If that byte completes lane 3, exactly one full word is pushed and the flush is a no-op.
- flush=1 with lane=0 and no byte: no-op, nothing pushed.
- Latency: the word is visible on word_out/word_valid the cycle after the edge that samples the completing byte or the flush, provided the FIFO was empty.
- FIFO: show-ahead. word_out/word_keep always reflect the head entry; word_valid = (level!=0).
- Pop occurs on an edge where word_valid && word_ready.
- Head data and keep are held stable while word_valid && !word_ready.
- When empty, word_out and word_keep show 0.
- Push with level<DEPTH: accepted.
- Push with level=DEPTH and a pop in the same cycle: accepted, level unchanged.
- Push with level=DEPTH and no pop: word dropped, FIFO unchanged, overflow set to 1. overflow stays set until reset. Packing continues normally.
- level: +1 on push only, -1 on pop only, unchanged on both or neither. Read/write pointers are LW bits wide and wrap mod 2*DEPTH.
- word_ready is ignored when empty; level never underflows.

Decomposition:
- Package encrypt_pkg holds:
  - BYTE_W=8, WORD_W=32, LANES=4;
  - typedef word_t, logic [31:0];
  - typedef keep_t, logic [3:0];
  - function keep_mask(lanes), returning (1<<lanes)-1.
- Sub-module sync_word_fifo (parameter DEPTH): 36-bit-wide show-ahead FIFO with push, pop, full, empty and level.
- The packer itself holds only the lane counter, accumulator, flush logic and overflow flag.

Test Plan:
- Bytes 11,22,33,44 on 4 consecutive cycles, word_ready=1:
  - one cycle after the 4th edge, word_out=32'h44332211, keep=4'hF, word_valid=1 for one cycle;
  - level returns to 0.
- Bytes AA,BB then flush pulse: word_out=32'h0000BBAA, keep=4'b0011. A second flush with no bytes produces no word.
- Bytes 01,02,03 then byte 04 together with flush in the same cycle: a single word 32'h04030201, keep=4'hF, and no empty extra word.
- word_ready=0, 20 bytes 00..13 (5 words) with DEPTH=4:
  - level saturates at 4 and overflow=1;
  - draining yields 03020100, 07060504, 0B0A0908, 0F0E0D0C;
  - word 13121110 is lost.
- FIFO full, then on the same cycle the 4th byte of a new word arrives and word_ready=1: the push is accepted, level stays 4, overflow stays 0.
- 2 bytes packed and 2 words queued, then rst pulsed low mid-stream: all outputs are 0 immediately. The next 4 bytes after release form a clean word starting at lane 0.
